// File: rtl/ex_mem_pipe_reg_if.sv
// ----------------------------------------------------------------------------
// ex_mem_pipe_reg_if
// Bundles the EX-side inputs, pipeline controls and MEM-side outputs of the
// EX/MEM pipeline register.
//   master : the EX stage / pipeline control (drives ex_*, stall, flush)
//   slave  : the EX/MEM register itself (drives mem_*, bubble_count)
// Parameters: DATA_W (ALU/store data width), REG_W (register number width),
//             CNT_W (bubble counter width).
// ----------------------------------------------------------------------------
interface ex_mem_pipe_reg_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              flush;
    logic              ex_valid;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_mem_to_reg;
    logic [DATA_W-1:0] ex_alu_result;
    logic [DATA_W-1:0] ex_store_data;
    logic [REG_W-1:0]  ex_write_reg;

    logic              mem_valid;
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic              mem_mem_write;
    logic              mem_mem_to_reg;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_store_data;
    logic [REG_W-1:0]  mem_write_reg;
    logic [CNT_W-1:0]  bubble_count;

    modport master (
        output stall, flush, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_alu_result, ex_store_data, ex_write_reg,
        input  mem_valid, mem_reg_write, mem_mem_read, mem_mem_write,
               mem_mem_to_reg, mem_alu_result, mem_store_data, mem_write_reg,
               bubble_count
    );

    modport slave (
        input  stall, flush, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write,
               ex_mem_to_reg, ex_alu_result, ex_store_data, ex_write_reg,
        output mem_valid, mem_reg_write, mem_mem_read, mem_mem_write,
               mem_mem_to_reg, mem_alu_result, mem_store_data, mem_write_reg,
               bubble_count
    );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// ----------------------------------------------------------------------------
// ex_mem_pipe_reg
// EX/MEM pipeline register of the 5-stage MIPS core. Captures ALU result,
// store data, control bits and destination register from EX and presents
// them to MEM, forwarding and hazard logic one cycle later.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears every output including the
//           bubble counter
//   bus   : ex_mem_pipe_reg_if.slave (ex_* / stall / flush in, mem_* and
//           bubble_count out)
// Edge priority is flush > stall > load. Invalid entries carry all-zero
// control bits; bubble_count saturates instead of wrapping.
// ----------------------------------------------------------------------------
module ex_mem_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    ex_mem_pipe_reg_if.slave    bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stage registers
    logic              valid_r;
    logic              reg_write_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic              mem_to_reg_r;
    logic [DATA_W-1:0] alu_result_r;
    logic [DATA_W-1:0] store_data_r;
    logic [REG_W-1:0]  write_reg_r;
    logic [CNT_W-1:0]  bubble_count_r;

    // Next-state values
    logic              load_en_s;
    logic              bubble_s;
    logic              valid_s;
    logic              reg_write_s;
    logic              mem_read_s;
    logic              mem_write_s;
    logic              mem_to_reg_s;
    logic [DATA_W-1:0] alu_result_s;
    logic [DATA_W-1:0] store_data_s;
    logic [REG_W-1:0]  write_reg_s;
    logic [CNT_W-1:0]  bubble_count_s;

    // Select the entry to latch this edge: flush bubble, held contents, or EX fields
    always_comb begin
        load_en_s      = 1'b0;
        bubble_s       = 1'b0;
        valid_s        = 1'b0;
        reg_write_s    = 1'b0;
        mem_read_s     = 1'b0;
        mem_write_s    = 1'b0;
        mem_to_reg_s   = 1'b0;
        alu_result_s   = {DATA_W{1'b0}};
        store_data_s   = {DATA_W{1'b0}};
        write_reg_s    = {REG_W{1'b0}};
        if (bus.flush) begin
            // Full bubble: everything cleared, data included
            load_en_s = 1'b1;
            bubble_s  = 1'b1;
        end else if (bus.stall) begin
            load_en_s = 1'b0;
            bubble_s  = 1'b0;
        end else begin
            load_en_s    = 1'b1;
            // Data is captured even for an invalid entry; only control is squashed
            alu_result_s = bus.ex_alu_result;
            store_data_s = bus.ex_store_data;
            if (bus.ex_valid) begin
                valid_s      = 1'b1;
                // Writes to $zero are architecturally meaningless; drop them here
                // so forwarding never matches register 0
                reg_write_s  = bus.ex_reg_write & (bus.ex_write_reg != {REG_W{1'b0}});
                mem_read_s   = bus.ex_mem_read;
                // A read+write conflict keeps the read and drops the write
                mem_write_s  = bus.ex_mem_write & ~bus.ex_mem_read;
                mem_to_reg_s = bus.ex_mem_to_reg;
                write_reg_s  = bus.ex_write_reg;
            end else begin
                bubble_s = 1'b1;
            end
        end
    end

    // Saturating bubble counter next value
    always_comb begin
        bubble_count_s = bubble_count_r;
        if (bubble_s && (bubble_count_r != CNT_MAX)) begin
            bubble_count_s = bubble_count_r + CNT_ONE;
        end else begin
            bubble_count_s = bubble_count_r;
        end
    end

    // Stage register update with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r        <= 1'b0;
            reg_write_r    <= 1'b0;
            mem_read_r     <= 1'b0;
            mem_write_r    <= 1'b0;
            mem_to_reg_r   <= 1'b0;
            alu_result_r   <= {DATA_W{1'b0}};
            store_data_r   <= {DATA_W{1'b0}};
            write_reg_r    <= {REG_W{1'b0}};
            bubble_count_r <= {CNT_W{1'b0}};
        end else if (load_en_s) begin
            valid_r        <= valid_s;
            reg_write_r    <= reg_write_s;
            mem_read_r     <= mem_read_s;
            mem_write_r    <= mem_write_s;
            mem_to_reg_r   <= mem_to_reg_s;
            alu_result_r   <= alu_result_s;
            store_data_r   <= store_data_s;
            write_reg_r    <= write_reg_s;
            bubble_count_r <= bubble_count_s;
        end else begin
            valid_r        <= valid_r;
            reg_write_r    <= reg_write_r;
            mem_read_r     <= mem_read_r;
            mem_write_r    <= mem_write_r;
            mem_to_reg_r   <= mem_to_reg_r;
            alu_result_r   <= alu_result_r;
            store_data_r   <= store_data_r;
            write_reg_r    <= write_reg_r;
            bubble_count_r <= bubble_count_r;
        end
    end

    // Outputs are driven straight from the stage registers
    assign bus.mem_valid      = valid_r;
    assign bus.mem_reg_write  = reg_write_r;
    assign bus.mem_mem_read   = mem_read_r;
    assign bus.mem_mem_write  = mem_write_r;
    assign bus.mem_mem_to_reg = mem_to_reg_r;
    assign bus.mem_alu_result = alu_result_r;
    assign bus.mem_store_data = store_data_r;
    assign bus.mem_write_reg  = write_reg_r;
    assign bus.bubble_count   = bubble_count_r;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_pipe_reg
// Self-checking bench for ex_mem_pipe_reg with a 4-bit bubble counter so
// saturation is reachable. A behavioural model predicts the MEM-side view;
// a negedge process compares it every cycle, and directed literal checks pin
// the key scenarios.
// ----------------------------------------------------------------------------
module tb_ex_mem_pipe_reg;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 4;

    logic clk;
    logic reset;
    int   pass_count;
    int   total_count;

    ex_mem_pipe_reg_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    ex_mem_pipe_reg #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_count++;
        if (act === exp) pass_count++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // The MEM-side view of what the last accepted instruction looks like.
    typedef struct packed {
        logic              valid;
        logic              rw;
        logic              mr;
        logic              mw;
        logic              m2r;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] sd;
        logic [REG_W-1:0]  wr;
    } entry_t;

    entry_t m_e;
    int     m_bubbles;   // unbounded count of bubbles since reset

    function automatic entry_t model_entry(input logic v, input logic rw, input logic mr,
                                           input logic mw, input logic m2r,
                                           input logic [DATA_W-1:0] alu,
                                           input logic [DATA_W-1:0] sd,
                                           input logic [REG_W-1:0] wr);
        entry_t e;
        e = '0;
        e.alu = alu;
        e.sd  = sd;
        if (v) begin
            e.valid = 1'b1;
            e.rw    = rw && (wr != 0);
            e.mr    = mr;
            e.mw    = (mr && mw) ? 1'b0 : mw;
            e.m2r   = m2r;
            e.wr    = wr;
        end
        return e;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_e       <= '0;
            m_bubbles <= 0;
        end else if (bus.flush) begin
            m_e       <= '0;
            m_bubbles <= m_bubbles + 1;
        end else if (!bus.stall) begin
            m_e <= model_entry(bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                               bus.ex_mem_to_reg, bus.ex_alu_result, bus.ex_store_data,
                               bus.ex_write_reg);
            if (!bus.ex_valid) m_bubbles <= m_bubbles + 1;
        end
    end

    // Per-cycle compare of the whole MEM-side view against the model
    always @(negedge clk) begin
        if (!reset) begin
            check("cycle_entry",
                  {bus.mem_valid, bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write,
                   bus.mem_mem_to_reg, bus.mem_alu_result, bus.mem_store_data, bus.mem_write_reg},
                  m_e);
            check("cycle_bubble_count", bus.bubble_count,
                  (m_bubbles > 15) ? 15 : m_bubbles);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic fl, input logic v, input logic rw,
                         input logic mr, input logic mw, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] wr);
        bus.stall         = st;
        bus.flush         = fl;
        bus.ex_valid      = v;
        bus.ex_reg_write  = rw;
        bus.ex_mem_read   = mr;
        bus.ex_mem_write  = mw;
        bus.ex_mem_to_reg = m2r;
        bus.ex_alu_result = alu;
        bus.ex_store_data = sd;
        bus.ex_write_reg  = wr;
    endtask

    task automatic drive_random(input logic st, input logic fl);
        logic [4:0] wr;
        wr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        drive(st, fl, ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), $urandom, $urandom, wr);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {bus.mem_valid, bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write,
                     bus.mem_mem_to_reg, bus.mem_alu_result, bus.mem_store_data,
                     bus.mem_write_reg, bus.bubble_count}, 128'd0);
    endtask

    initial begin
        pass_count  = 0;
        total_count = 0;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0000_abcd, 5'd17);
        cyc();
        cyc();
        check_all_zero("reset_state");
        @(negedge clk);
        reset = 1'b0;

        // Normal load
        cyc();
        check("load_wr", bus.mem_write_reg, 5'd17);
        check("load_rw", bus.mem_reg_write, 1'b1);
        check("load_alu", bus.mem_alu_result, 32'h0000_1234);
        check("load_valid", bus.mem_valid, 1'b1);

        // Writes to register 0 are suppressed
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_5555, 32'h0, 5'd0);
        cyc();
        check("zero_rw", bus.mem_reg_write, 1'b0);
        check("zero_valid", bus.mem_valid, 1'b1);
        check("zero_wr", bus.mem_write_reg, 5'd0);

        // Stall holds contents for 3 cycles
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0099, 32'h0, 5'd9);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive_random(1'b1, 1'b0);
            cyc();
            check("stall_wr", bus.mem_write_reg, 5'd9);
            check("stall_alu", bus.mem_alu_result, 32'h0000_0099);
            check("stall_bc", bus.bubble_count, 4'd0);
        end

        // Flush beats stall
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hffff_ffff, 32'h1, 5'd3);
        cyc();
        check("flush_valid", bus.mem_valid, 1'b0);
        check("flush_ctrl", {bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write,
                             bus.mem_mem_to_reg}, 4'd0);
        check("flush_wr", bus.mem_write_reg, 5'd0);
        check("flush_bc", bus.bubble_count, 4'd1);

        // Read/write conflict keeps the read
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'hdead_beef, 5'd4);
        cyc();
        check("conflict_mw", bus.mem_mem_write, 1'b0);
        check("conflict_mr", bus.mem_mem_read, 1'b1);
        check("conflict_sd", bus.mem_store_data, 32'hdead_beef);

        // Invalid load: control squashed, data captured, counted as bubble
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_7777, 32'h0000_8888, 5'd12);
        cyc();
        check("invalid_ctrl", {bus.mem_valid, bus.mem_reg_write, bus.mem_mem_read,
                               bus.mem_mem_write, bus.mem_mem_to_reg, bus.mem_write_reg}, 10'd0);
        check("invalid_alu", bus.mem_alu_result, 32'h0000_7777);
        check("invalid_bc", bus.bubble_count, 4'd2);

        // 20 flushes saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            drive_random(1'($urandom), 1'b1);
            cyc();
        end
        check("saturate_bc", bus.bubble_count, 4'd15);

        // Reset between edges while stalled
        drive_random(1'b1, 1'b0);
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        #1;
        reset = 1'b0;
        cyc();
        check_all_zero("reset_then_stall");

        // Randomized traffic against the model, with occasional async resets
        for (int i = 0; i < 400; i++) begin
            drive_random(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 63) == 0) begin
                reset = 1'b1;
                #1;
                check_all_zero("rand_reset");
                reset = 1'b0;
            end
            cyc();
        end

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end
endmodule
